// File: rtl/trace_pkt_writer.sv
// Write-side sequencer for the trace packet ring: assembles 8-word packets into RAM slots,
// publishes a Gray write pointer to the reader domain, and counts dropped and malformed packets.
module trace_pkt_writer #(
  parameter int unsigned SLOT_BITS     = 4,
  parameter int unsigned WORDS_PER_PKT = 8
) (
  input  logic                 traceClkin,
  input  logic                 rst,
  input  logic                 sync,
  input  logic                 WdAvail,
  input  logic [15:0]          PacketWd,
  input  logic                 PacketReset,
  input  logic                 PacketCommit,
  input  logic [SLOT_BITS:0]   rdPtrGray,
  output logic                 ramWrEn,
  output logic [SLOT_BITS+2:0] ramWrAddr,
  output logic [15:0]          ramWrData,
  output logic [SLOT_BITS:0]   wrPtrGray,
  output logic                 full,
  output logic [7:0]           dropCount,
  output logic [7:0]           badCount
);

  localparam int unsigned PTR_W  = SLOT_BITS + 1;
  localparam int unsigned ADDR_W = SLOT_BITS + 3;
  localparam int unsigned IDX_W  = 4;
  localparam logic [IDX_W-1:0] PKT_LEN = IDX_W'(WORDS_PER_PKT);

  typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

  state_t             state, state_d;
  logic               sync_q1, sync_q2;
  logic [PTR_W-1:0]   rd_q1, rd_q2, rd_bin;
  logic [PTR_W-1:0]   wr_bin, wr_bin_d, wr_inc, wr_gray_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic               over, over_d;
  logic               wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [15:0]        wr_data_d;
  logic               full_d;
  logic [7:0]         drop_d, bad_d;

  // Gray-to-binary of the synchronised reader pointer
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      rd_bin[i] = ^(rd_q2 >> i);
    end
  end

  assign wr_inc = wr_bin + PTR_W'(1);
  assign full_d = (wr_bin[PTR_W-1] != rd_bin[PTR_W-1]) &&
                  (wr_bin[SLOT_BITS-1:0] == rd_bin[SLOT_BITS-1:0]);

  // Next-state and registered-output logic; one event acts per cycle by priority
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    over_d    = over;
    wr_bin_d  = wr_bin;
    wr_gray_d = wrPtrGray;
    wr_en_d   = 1'b0;
    wr_addr_d = ramWrAddr;
    wr_data_d = ramWrData;
    drop_d    = dropCount;
    bad_d     = badCount;

    if (!sync_q2 || PacketReset) begin
      state_d = IDLE;
      idx_d   = '0;
      over_d  = 1'b0;
    end else if (PacketCommit) begin
      state_d = IDLE;
      idx_d   = '0;
      over_d  = 1'b0;
      case (state)
        FILL: begin
          if (idx == PKT_LEN && !over) begin
            wr_bin_d  = wr_inc;
            wr_gray_d = wr_inc ^ (wr_inc >> 1);
          end else if (badCount != 8'hFF) begin
            bad_d = badCount + 8'd1;
          end
        end
        DROP: begin
          if (dropCount != 8'hFF) drop_d = dropCount + 8'd1;
        end
        default: ;
      endcase
    end else if (WdAvail) begin
      case (state)
        IDLE: begin
          if (!full) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bin[SLOT_BITS-1:0], 3'd0};
            wr_data_d = PacketWd;
            idx_d     = IDX_W'(1);
            state_d   = FILL;
          end else begin
            state_d = DROP;
          end
        end
        FILL: begin
          if (idx < PKT_LEN) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bin[SLOT_BITS-1:0], idx[2:0]};
            wr_data_d = PacketWd;
            idx_d     = idx + IDX_W'(1);
          end else begin
            over_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge traceClkin) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      over      <= 1'b0;
      wr_bin    <= '0;
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      rd_q1     <= '0;
      rd_q2     <= '0;
      ramWrEn   <= 1'b0;
      ramWrAddr <= '0;
      ramWrData <= '0;
      wrPtrGray <= '0;
      full      <= 1'b0;
      dropCount <= '0;
      badCount  <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      over      <= over_d;
      wr_bin    <= wr_bin_d;
      sync_q1   <= sync;
      sync_q2   <= sync_q1;
      rd_q1     <= rdPtrGray;
      rd_q2     <= rd_q1;
      ramWrEn   <= wr_en_d;
      ramWrAddr <= wr_addr_d;
      ramWrData <= wr_data_d;
      wrPtrGray <= wr_gray_d;
      full      <= full_d;
      dropCount <= drop_d;
      badCount  <= bad_d;
    end
  end

endmodule

// File: tb/tb_trace_pkt_writer.sv
// Bench for trace_pkt_writer: directed vector table, hand-built corner sequences and a
// randomized packet/reader mix checked against a packet-level model of the ring.
module tb_trace_pkt_writer;

  logic        traceClkin = 1'b0;
  logic        rst, sync, WdAvail, PacketReset, PacketCommit;
  logic [15:0] PacketWd;
  logic [4:0]  rdPtrGray;
  logic        ramWrEn;
  logic [6:0]  ramWrAddr;
  logic [15:0] ramWrData;
  logic [4:0]  wrPtrGray;
  logic        full;
  logic [7:0]  dropCount, badCount;

  always #5 traceClkin = ~traceClkin;

  trace_pkt_writer #(.SLOT_BITS(4), .WORDS_PER_PKT(8)) dut (
    .traceClkin(traceClkin), .rst(rst), .sync(sync), .WdAvail(WdAvail),
    .PacketWd(PacketWd), .PacketReset(PacketReset), .PacketCommit(PacketCommit),
    .rdPtrGray(rdPtrGray), .ramWrEn(ramWrEn), .ramWrAddr(ramWrAddr),
    .ramWrData(ramWrData), .wrPtrGray(wrPtrGray), .full(full),
    .dropCount(dropCount), .badCount(badCount)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [4:0] gray(input int x);
    int y;
    y = x & 31;
    return 5'(y ^ (y >> 1));
  endfunction

  // Packet-level reference: pointers as plain counters, current packet as a word queue
  int          m_wr = 0, m_rd = 0, m_mode = 0, m_drop = 0, m_bad = 0, m_writes = 0;
  bit          m_over = 0, m_good = 0;
  int          m_slot = 0;
  logic [15:0] m_words[$];
  logic [15:0] m_pkt[8];

  function automatic int occ();
    return (m_wr - m_rd) & 31;
  endfunction

  task automatic model_evt(input bit wd, input logic [15:0] d, input bit c, input bit r);
    if (r) begin
      m_mode = 0; m_words.delete(); m_over = 0;
    end else if (c) begin
      m_good = 0;
      if (m_mode == 1) begin
        if (m_words.size() == 8 && !m_over) begin
          m_good = 1;
          m_slot = m_wr & 15;
          for (int k = 0; k < 8; k++) m_pkt[k] = m_words[k];
          m_wr = (m_wr + 1) & 31;
        end else if (m_bad < 255) m_bad++;
      end else if (m_mode == 2) begin
        if (m_drop < 255) m_drop++;
      end
      m_mode = 0; m_words.delete(); m_over = 0;
    end else if (wd) begin
      if (m_mode == 0) begin
        if (occ() == 16) m_mode = 2;
        else begin m_mode = 1; m_words.push_back(d); m_writes++; end
      end else if (m_mode == 1) begin
        if (m_words.size() < 8) begin m_words.push_back(d); m_writes++; end
        else m_over = 1;
      end
    end
  endtask

  // RAM image rebuilt from the write port
  logic [15:0] mem [0:127];
  int          dut_writes = 0;
  always @(posedge traceClkin) begin
    if (ramWrEn) begin
      mem[ramWrAddr] = ramWrData;
      dut_writes++;
    end
  end

  logic [4:0] prev_gray = 5'd0;
  always @(negedge traceClkin) begin
    if (!rst && wrPtrGray !== prev_gray)
      check("gray_step", 32'($countones(wrPtrGray ^ prev_gray)), 1);
    prev_gray = wrPtrGray;
  end

  task automatic tick(input bit wd, input logic [15:0] d, input bit c, input bit r);
    WdAvail = wd; PacketWd = d; PacketCommit = c; PacketReset = r;
    model_evt(wd, d, c, r);
    @(negedge traceClkin);
    WdAvail = 1'b0; PacketCommit = 1'b0; PacketReset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic send_words(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      tick(1'b1, 16'($urandom), 1'b0, 1'b0);
      if (gaps) idle(int'($urandom_range(0, 1)));
    end
  endtask

  task automatic do_commit(input string tag);
    bit ok;
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge traceClkin);
    check({tag, "_ptr"}, wrPtrGray, gray(m_wr));
    check({tag, "_drop"}, dropCount, m_drop);
    check({tag, "_bad"}, badCount, m_bad);
    check({tag, "_full"}, full, occ() == 16);
    check({tag, "_writes"}, dut_writes, m_writes);
    if (m_good) begin
      ok = 1;
      for (int k = 0; k < 8; k++)
        if (mem[m_slot * 8 + k] !== m_pkt[k]) ok = 0;
      check({tag, "_slot"}, 32'(ok), 1);
    end
  endtask

  task automatic reader_step();
    if (occ() > 0) begin
      m_rd = (m_rd + 1) & 31;
      rdPtrGray = gray(m_rd);
      repeat (3) @(negedge traceClkin);
      check("rd_full", full, occ() == 16);
      @(negedge traceClkin);
    end
  endtask

  typedef struct {
    bit          wd;
    logic [15:0] d;
    bit          c;
    bit          r;
    bit          en;
    logic [6:0]  addr;
    logic [4:0]  ptr;
    logic [7:0]  bad;
  } vec_t;

  function automatic vec_t mk(input bit wd, input logic [15:0] d, input bit c, input bit r,
                              input bit en, input logic [6:0] a, input logic [4:0] p,
                              input logic [7:0] b);
    vec_t v;
    v.wd = wd; v.d = d; v.c = c; v.r = r; v.en = en; v.addr = a; v.ptr = p; v.bad = b;
    return v;
  endfunction

  vec_t tbl[27];

  initial begin
    for (int k = 0; k < 8; k++) tbl[k] = mk(1, 16'(16'h1000 + k), 0, 0, 1, 7'(k), 5'h00, 8'd0);
    tbl[8] = mk(0, 16'h0, 1, 0, 0, 7'd0, 5'h01, 8'd0);
    tbl[9] = mk(0, 16'h0, 0, 0, 0, 7'd0, 5'h01, 8'd0);
    for (int k = 0; k < 5; k++) tbl[10+k] = mk(1, 16'(16'h2000 + k), 0, 0, 1, 7'(8 + k), 5'h01, 8'd0);
    tbl[15] = mk(0, 16'h0, 1, 0, 0, 7'd0, 5'h01, 8'd1);
    tbl[16] = mk(1, 16'h2222, 0, 1, 0, 7'd0, 5'h01, 8'd1);
    for (int k = 0; k < 8; k++) tbl[17+k] = mk(1, 16'(16'h3000 + k), 0, 0, 1, 7'(8 + k), 5'h01, 8'd1);
    tbl[25] = mk(0, 16'h0, 1, 0, 0, 7'd0, 5'h03, 8'd1);
    tbl[26] = mk(0, 16'h0, 0, 0, 0, 7'd0, 5'h03, 8'd1);

    rst = 1'b1; sync = 1'b1; WdAvail = 1'b0; PacketWd = 16'h0;
    PacketReset = 1'b0; PacketCommit = 1'b0; rdPtrGray = 5'd0;
    repeat (3) @(negedge traceClkin);
    check("rst_en", ramWrEn, 0);
    check("rst_addr", ramWrAddr, 0);
    check("rst_data", ramWrData, 0);
    check("rst_ptr", wrPtrGray, 0);
    check("rst_full", full, 0);
    check("rst_drop", dropCount, 0);
    check("rst_bad", badCount, 0);
    rst = 1'b0;
    repeat (4) @(negedge traceClkin);

    for (int i = 0; i < 27; i++) begin
      tick(tbl[i].wd, tbl[i].d, tbl[i].c, tbl[i].r);
      check($sformatf("tbl%0d_en", i), ramWrEn, tbl[i].en);
      if (tbl[i].en) begin
        check($sformatf("tbl%0d_addr", i), ramWrAddr, tbl[i].addr);
        check($sformatf("tbl%0d_data", i), ramWrData, tbl[i].d);
      end
      check($sformatf("tbl%0d_ptr", i), wrPtrGray, tbl[i].ptr);
      check($sformatf("tbl%0d_bad", i), badCount, tbl[i].bad);
    end

    // Partial packet abandoned by PacketReset, then a clean packet
    send_words(3, 0);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    send_words(8, 1);
    do_commit("rst_restart");
    check("rst_restart_ptr_abs", wrPtrGray, 5'h02);

    // Overlong packet: only 8 writes, counted as bad
    send_words(9, 0);
    do_commit("long");
    check("long_bad_abs", badCount, 2);

    // Loss of sync discards the partial packet; a later commit does nothing
    send_words(3, 0);
    sync = 1'b0;
    model_evt(1'b0, 16'h0, 1'b0, 1'b1);
    idle(4);
    sync = 1'b1;
    idle(4);
    do_commit("sync_drop");

    // Fill the ring with the reader parked at 0
    while (occ() < 16) begin
      send_words(8, 1);
      do_commit("fill");
    end
    check("full_ptr_abs", wrPtrGray, 5'h18);
    check("full_set", full, 1);

    // Packet starting while full is dropped even if a slot frees mid-packet
    send_words(3, 0);
    reader_step();
    send_words(5, 0);
    do_commit("drop");
    check("drop_abs", dropCount, 1);

    // Randomized packets interleaved with reader progress
    for (int it = 0; it < 90; it++) begin
      int kind;
      if ($urandom_range(0, 9) < 5) begin
        reader_step();
        if ($urandom_range(0, 1) == 1) reader_step();
      end
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) begin
        send_words(8, 1); do_commit("rnd_ok");
      end else if (kind == 6) begin
        send_words(int'($urandom_range(1, 7)), 1); do_commit("rnd_short");
      end else if (kind == 7) begin
        send_words(int'($urandom_range(9, 10)), 0); do_commit("rnd_long");
      end else if (kind == 8) begin
        send_words(int'($urandom_range(1, 7)), 1);
        tick(1'b0, 16'h0, 1'b0, 1'b1);
      end else begin
        send_words(int'($urandom_range(1, 7)), 0);
        tick(1'b1, 16'hBEEF, 1'b0, 1'b1);
        send_words(8, 0); do_commit("rnd_combo");
      end
    end

    // Reset in the middle of a packet
    send_words(3, 0);
    WdAvail = 1'b1; PacketWd = 16'hDEAD; rst = 1'b1;
    @(negedge traceClkin);
    WdAvail = 1'b0;
    check("mid_rst_en", ramWrEn, 0);
    check("mid_rst_addr", ramWrAddr, 0);
    check("mid_rst_ptr", wrPtrGray, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_drop", dropCount, 0);
    check("mid_rst_bad", badCount, 0);
    @(negedge traceClkin);
    rst = 1'b0;
    check("total_writes", dut_writes, m_writes);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_pkt_writer.md
Name: trace_pkt_writer

Overview:
Write-side controller for the trace packet buffer. Sits directly above the trace front end in the traceClkin domain. Takes its word stream and packet commit/reset flags and sequences writes of complete 8-word packets into slots of a dual-port RAM ring. Publishes a Gray-coded write pointer to the clk-domain reader, drops packets on overflow, and counts drops and malformed packets.

Parameters:
SLOT_BITS, 4, log2 of packet slots in the ring (default 16 slots)
WORDS_PER_PKT, 8, 16-bit words per complete packet; fixed at 8 (word index is 3 bits)

Ports:
traceClkin  input  1  trace clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
sync  input  1  front end in-sync indicator (from clk domain, double-flopped internally)
WdAvail  input  1  word valid, one-cycle pulse per word
PacketWd  input  16  packet word, valid with WdAvail
PacketReset  input  1  discard current partial packet
PacketCommit  input  1  current packet complete
rdPtrGray  input  SLOT_BITS+1  reader slot pointer, Gray, clk domain (double-flopped internally)
ramWrEn  output  1  RAM write strobe
ramWrAddr  output  SLOT_BITS+3  {slot, word index}
ramWrData  output  16  RAM write data
wrPtrGray  output  SLOT_BITS+1  committed write slot pointer, Gray
full  output  1  no free slot
dropCount  output  8  saturating count of packets dropped for full
badCount  output  8  saturating count of short/overlong packets discarded

Behaviour:
- Reset: ramWrEn=0, ramWrAddr=0, ramWrData=0, wrPtrGray=0, full=0, dropCount=0, badCount=0, state=IDLE, word index=0, internal binary write pointer=0, sync flops=0.
- Synchronisers: rdPtrGray and sync each pass through 2 flops before use. Synced rd pointer is Gray-to-binary converted combinationally.
- full = (wrBin[SLOT_BITS] != rdBin[SLOT_BITS]) && (wrBin[SLOT_BITS-1:0] == rdBin[SLOT_BITS-1:0]). It is registered and updated every cycle.
- Input priority per cycle: synced sync low > PacketReset > PacketCommit > WdAvail. Only the highest-priority event acts.
- States:
  - IDLE:
    - WdAvail with full=0: write word 0 and go to FILL.
    - WdAvail with full=1: go to DROP.
    - PacketCommit: no action.
  - FILL:
    - WdAvail with index<8: write the word at {wrBin[SLOT_BITS-1:0], index}, then index+1.
    - WdAvail with index==8: set overlong flag, no write.
    - PacketCommit with index==8 and no overlong flag: wrBin+1, wrPtrGray=gray(wrBin+1), go to IDLE.
    - PacketCommit otherwise: badCount+1, no pointer move, go to IDLE.
  - DROP:
    - Ignore words.
    - PacketCommit: dropCount+1, go to IDLE.
    - PacketReset: go to IDLE, no count.
- PacketReset or sync low, any state: index=0, overlong cleared, go to IDLE. No pointer move, no count. RAM contents of the uncommitted slot are don't-care.
- RAM write latency: registered. ramWrEn/addr/data assert the cycle after the sampled WdAvail, for exactly 1 cycle.
- Pointer publish: wrPtrGray changes the cycle after the sampled PacketCommit. The last word's write (issued at or before that cycle) therefore always precedes the pointer update. wrPtrGray changes by exactly one Gray step per commit.
- Full is evaluated only at packet start. A slot freed mid-DROP does not resume the dropped packet.
- Wrap-around: wrBin is SLOT_BITS+1 bits and wraps naturally from all-ones to 0.
- Counters saturate at 255 and never wrap.
- Reset mid-packet: all state returns to reset values on the next edge. No RAM write occurs in that cycle.

Test Plan:
- Reset then 8 WdAvail words 0x1000..0x1007, then PacketCommit -> ramWrEn pulses at addr 0..7 with matching data; wrPtrGray 0->1 one cycle after commit; counters 0.
- 16 complete packets with rdPtrGray held 0 -> full=1 after 16th commit, wrPtrGray=gray(16)=0x18. 17th packet of 8 words+commit -> no ramWrEn, dropCount=1, wrPtrGray unchanged.
- 5 words then PacketCommit -> badCount=1, wrPtrGray unchanged. Next 8-word packet rewrites the same slot at word addresses 0..7.
- 3 words then PacketReset, then 8 words+commit -> badCount=0; writes restart at word index 0; pointer advances by 1.
- 9 words then commit -> 8 writes only, badCount=1, no pointer move. WdAvail and PacketReset in the same cycle -> reset wins, no write.
- Drive rdPtrGray through 32 reader steps interleaved with 40 packet commits -> wrPtrGray wraps past 0x10 with single-bit changes; full tracks the occupancy of 16 within 3 cycles of rdPtrGray change.
